axis_route_update_ctrl: RTL and testbench

Sequencer for safe run-time reconfiguration of the per-region routes (`route_out`, tdest) that drive the DTU-side inputs of the vFPGA AXI4-Stream data switch. It accepts one route-change request at a time and waits for the target region's DTU sink stream to reach a packet boundary. It then gates that stream, lets the switch arbiter settle, commits the new route, and releases the gate. It sits on the valid/ready/last handshake wires between the DTU sinks and the switch; tdata, tkeep and tid bypass it.

---
 rtl/axis_route_update_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_axis_route_update_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_route_update_ctrl.sv
// ---------------------------------------------------------------------------
// axis_route_update_ctrl
//
// Purpose: sequences a run-time change of one region's tdest (route_out entry)
// feeding the vFPGA AXI4-Stream switch. A request is accepted, the target
// region's DTU sink stream is drained to a packet boundary, that stream is
// gated for SETTLE_CYCLES so the switch arbiter can settle, the new route is
// committed, the gate is released and a completion is returned.
// Only valid/ready/last pass through this block; tdata/tkeep/tid bypass it.
//
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   cfg_req_valid/ready/id/route  route-change request (one at a time)
//   cfg_rsp_valid/ready/id/err    completion (err: 00 ok, 01 timeout, 10 bad id)
//   s_tvalid, s_tlast, s_tready   per-region DTU sink handshake
//   m_tvalid, m_tready            per-region switch-input handshake
//   route_out                     per-region 8-bit tdest, region i at [i*8 +: 8]
//   busy                          sequencer not idle
// ---------------------------------------------------------------------------
module axis_route_update_ctrl #(
  parameter int         N_ID          = 4,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         DRAIN_TIMEOUT = 1024,
  parameter logic [7:0] DEFAULT_ROUTE = 8'h00
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cfg_req_valid,
  output logic              cfg_req_ready,
  input  logic [7:0]        cfg_req_id,
  input  logic [7:0]        cfg_req_route,
  output logic              cfg_rsp_valid,
  input  logic              cfg_rsp_ready,
  output logic [7:0]        cfg_rsp_id,
  output logic [1:0]        cfg_rsp_err,
  input  logic [N_ID-1:0]   s_tvalid,
  input  logic [N_ID-1:0]   s_tlast,
  output logic [N_ID-1:0]   s_tready,
  output logic [N_ID-1:0]   m_tvalid,
  input  logic [N_ID-1:0]   m_tready,
  output logic [N_ID*8-1:0] route_out,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SETTLE,
    ST_COMMIT,
    ST_RESP
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_BAD_ID  = 2'b10;

  state_t            state_q, state_d;
  logic [7:0]        req_id_q, req_id_d;
  logic [7:0]        req_route_q, req_route_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [N_ID-1:0]   gate_q, gate_d;
  logic [N_ID-1:0]   in_pkt_q, in_pkt_d;
  logic [7:0]        route_q [N_ID];
  logic [7:0]        route_d [N_ID];
  logic [7:0]        rsp_id_q, rsp_id_d;
  logic [1:0]        rsp_err_q, rsp_err_d;

  logic [N_ID-1:0]   quiet;
  logic [N_ID-1:0]   id_hit;     // one-hot decode of the latched region id
  logic              quiet_sel;

  // -------------------------------------------------------------------------
  // Per-region passthrough, packet tracker and boundary detection
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_ID; gi++) begin : g_region
    assign m_tvalid[gi] = s_tvalid[gi] & ~gate_q[gi];
    assign s_tready[gi] = m_tready[gi] & ~gate_q[gi];

    // Tracks on m_tready rather than s_tready: a beat seen while gated cannot
    // be withdrawn, so it will transfer later with the same tlast and the
    // tracked state is equivalent.
    assign in_pkt_d[gi] = (s_tvalid[gi] & m_tready[gi]) ? ~s_tlast[gi]
                                                        : in_pkt_q[gi];

    // Quiet: either the last beat is transferring this cycle, or nothing is
    // offered and we are between packets. A pending non-last beat keeps the
    // region busy, so an offered beat is never cut off by the gate.
    assign quiet[gi] = s_tvalid[gi] ? (m_tready[gi] & s_tlast[gi])
                                    : ~in_pkt_q[gi];

    assign id_hit[gi] = (req_id_q == 8'(gi));

    assign route_out[gi*8 +: 8] = route_q[gi];
  end

  assign quiet_sel     = |(quiet & id_hit);
  assign cfg_rsp_valid = (state_q == ST_RESP);
  assign cfg_rsp_id    = rsp_id_q;
  assign cfg_rsp_err   = rsp_err_q;
  assign busy          = (state_q != ST_IDLE);

  // -------------------------------------------------------------------------
  // Sequencer next-state / outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    req_id_d      = req_id_q;
    req_route_d   = req_route_q;
    cnt_d         = cnt_q;
    gate_d        = gate_q;
    route_d       = route_q;
    rsp_id_d      = rsp_id_q;
    rsp_err_d     = rsp_err_q;
    cfg_req_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cfg_req_ready = ~areset;
        if (cfg_req_valid && !areset) begin
          req_id_d    = cfg_req_id;
          req_route_d = cfg_req_route;
          cnt_d       = '0;
          if ({1'b0, cfg_req_id} >= 9'(N_ID)) begin
            rsp_id_d  = cfg_req_id;
            rsp_err_d = ERR_BAD_ID;
            state_d   = ST_RESP;
          end else begin
            state_d   = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // Boundary wins over timeout when both occur in the same cycle.
        if (quiet_sel) begin
          gate_d  = gate_q | id_hit;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else if (cnt_q == 32'(DRAIN_TIMEOUT - 1)) begin
          rsp_id_d  = req_id_q;
          rsp_err_d = ERR_TIMEOUT;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_COMMIT: begin
        for (int i = 0; i < N_ID; i++) begin
          if (id_hit[i]) begin
            route_d[i] = req_route_q;
          end
        end
        // Route update and gate release land on the same edge.
        gate_d    = gate_q & ~id_hit;
        rsp_id_d  = req_id_q;
        rsp_err_d = ERR_OK;
        state_d   = ST_RESP;
      end

      ST_RESP: begin
        if (cfg_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      req_id_q    <= '0;
      req_route_q <= '0;
      cnt_q       <= '0;
      gate_q      <= '0;
      in_pkt_q    <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= ERR_OK;
      for (int i = 0; i < N_ID; i++) begin
        route_q[i] <= DEFAULT_ROUTE;
      end
    end else begin
      state_q     <= state_d;
      req_id_q    <= req_id_d;
      req_route_q <= req_route_d;
      cnt_q       <= cnt_d;
      gate_q      <= gate_d;
      in_pkt_q    <= in_pkt_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      for (int i = 0; i < N_ID; i++) begin
        route_q[i] <= route_d[i];
      end
    end
  end

endmodule

// File: tb/tb_axis_route_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axis_route_update_ctrl
//
// Directed bench for axis_route_update_ctrl: expected completions are queued
// when a request is driven and popped when the DUT responds; gating, route
// and latency expectations come from the documented cycle timeline.
// ---------------------------------------------------------------------------
module tb_axis_route_update_ctrl;

  localparam int         N_ID   = 4;
  localparam int         SETTLE = 4;
  localparam int         DT     = 16;
  localparam logic [7:0] DEF    = 8'h00;

  logic              aclk = 1'b0;
  logic              areset;
  logic              cfg_req_valid;
  logic              cfg_req_ready;
  logic [7:0]        cfg_req_id;
  logic [7:0]        cfg_req_route;
  logic              cfg_rsp_valid;
  logic              cfg_rsp_ready;
  logic [7:0]        cfg_rsp_id;
  logic [1:0]        cfg_rsp_err;
  logic [N_ID-1:0]   s_tvalid;
  logic [N_ID-1:0]   s_tlast;
  logic [N_ID-1:0]   s_tready;
  logic [N_ID-1:0]   m_tvalid;
  logic [N_ID-1:0]   m_tready;
  logic [N_ID*8-1:0] route_out;
  logic              busy;

  always #5 aclk = ~aclk;

  axis_route_update_ctrl #(
    .N_ID         (N_ID),
    .SETTLE_CYCLES(SETTLE),
    .DRAIN_TIMEOUT(DT),
    .DEFAULT_ROUTE(DEF)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_req_valid(cfg_req_valid),
    .cfg_req_ready(cfg_req_ready),
    .cfg_req_id   (cfg_req_id),
    .cfg_req_route(cfg_req_route),
    .cfg_rsp_valid(cfg_rsp_valid),
    .cfg_rsp_ready(cfg_rsp_ready),
    .cfg_rsp_id   (cfg_rsp_id),
    .cfg_rsp_err  (cfg_rsp_err),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .route_out    (route_out),
    .busy         (busy)
  );

  typedef struct {
    logic [7:0] id;
    logic [1:0] err;
  } rsp_t;

  rsp_t       sb_q[$];
  rsp_t       dropped;
  logic [7:0] exp_route [N_ID];
  int         checks   = 0;
  int         failures = 0;
  int         fwd0      = 0;
  int         fwd0_last = 0;
  int         base, base_last;

  // Beats forwarded on region 0, sampled mid-cycle (transfer at next edge).
  always @(negedge aclk) begin
    if (areset === 1'b0 && m_tvalid[0] === 1'b1 && m_tready[0] === 1'b1) begin
      fwd0 <= fwd0 + 1;
      if (s_tlast[0] === 1'b1) fwd0_last <= fwd0_last + 1;
    end
  end

  function automatic logic [N_ID*8-1:0] exp_flat();
    logic [N_ID*8-1:0] r;
    r = '0;
    for (int i = 0; i < N_ID; i++) r[i*8 +: 8] = exp_route[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_req(input logic [7:0] id, input logic [7:0] route, input logic [1:0] err);
    rsp_t e;
    chk("req_ready_idle", cfg_req_ready, 1);
    cfg_req_valid = 1'b1;
    cfg_req_id    = id;
    cfg_req_route = route;
    e.id  = id;
    e.err = err;
    sb_q.push_back(e);
    $display("REQ id=%0d route=0x%02h expect_err=%0d t=%0t", id, route, err, $time);
    tick();
    cfg_req_valid = 1'b0;
    chk("req_ready_after_accept", cfg_req_ready, 0);
  endtask

  task automatic check_rsp();
    rsp_t e;
    chk("rsp_valid", cfg_rsp_valid, 1);
    if (sb_q.size() == 0) begin
      chk("rsp_scoreboard_nonempty", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      chk("rsp_id", cfg_rsp_id, e.id);
      chk("rsp_err", cfg_rsp_err, e.err);
    end
    $display("RSP id=%0d err=%0d t=%0t", cfg_rsp_id, cfg_rsp_err, $time);
  endtask

  // Called at T+1; waits (bounded) for the response and consumes it.
  task automatic wait_rsp(input int exp_lat);
    int n;
    n = 1;
    while (cfg_rsp_valid !== 1'b1 && n < exp_lat + 8) begin
      tick();
      n++;
    end
    chk("rsp_latency", n, exp_lat);
    if (cfg_rsp_valid === 1'b1) check_rsp();
    tick();
    chk("idle_after_rsp", busy, 0);
  endtask

  initial begin
    areset        = 1'b1;
    cfg_req_valid = 1'b0;
    cfg_req_id    = '0;
    cfg_req_route = '0;
    cfg_rsp_ready = 1'b1;
    s_tvalid      = '0;
    s_tlast       = '0;
    m_tready      = '1;
    for (int i = 0; i < N_ID; i++) exp_route[i] = DEF;

    // ---------------- reset state ----------------
    tick();
    tick();
    s_tvalid = 4'b1010;
    #1;
    chk("rst_req_ready", cfg_req_ready, 0);
    chk("rst_rsp_valid", cfg_rsp_valid, 0);
    chk("rst_rsp_id", cfg_rsp_id, 0);
    chk("rst_rsp_err", cfg_rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_route", route_out, exp_flat());
    chk("rst_m_tvalid", m_tvalid, 4'b1010);
    chk("rst_s_tready", s_tready, 4'b1111);
    areset   = 1'b0;
    s_tvalid = '0;
    #1;
    chk("req_ready_after_reset", cfg_req_ready, 1);
    tick();

    // ---------------- idle region 1, route 5C ----------------
    s_tvalid[0] = 1'b1;
    s_tlast[0]  = 1'b1;
    do_req(8'd1, 8'h5C, 2'b00);                       // T+1
    chk("t1_gate_low_drain", s_tready[1], 1);
    chk("t1_busy", busy, 1);
    tick();                                            // T+2
    for (int k = 2; k <= 5; k++) begin
      chk("t1_gate_high", s_tready[1], 0);
      chk("t1_region0_ungated", m_tvalid[0], 1);
      chk("t1_route_old", route_out, exp_flat());
      tick();
    end                                                // T+6
    tick();                                            // T+7
    exp_route[1] = 8'h5C;
    chk("t1_route_new", route_out, exp_flat());
    chk("t1_gate_released", s_tready[1], 1);
    check_rsp();
    chk("t1_req_ready_in_resp", cfg_req_ready, 0);
    tick();                                            // T+8
    chk("t1_req_ready_back", cfg_req_ready, 1);
    chk("t1_idle", busy, 0);
    s_tvalid[0] = 1'b0;
    s_tlast[0]  = 1'b0;

    // ---------------- region 0 mid 8-beat packet ----------------
    base      = fwd0;
    base_last = fwd0_last;
    s_tvalid[0] = 1'b1;
    s_tlast[0]  = 1'b0;
    for (int b = 0; b < 3; b++) begin
      chk("t2_pre_beat", m_tvalid[0], 1);
      tick();
    end
    do_req(8'd0, 8'hA3, 2'b00);                       // beat 3 accepted; T+1
    for (int b = 4; b <= 7; b++) begin
      s_tlast[0] = (b == 7);
      #1;
      chk("t2_no_gate_mid_pkt", s_tready[0], 1);
      chk("t2_beat_fwd", m_tvalid[0], 1);
      tick();
    end                                                // T+5
    s_tlast[0] = 1'b1;                                // next packet: one beat
    chk("t2_beats_forwarded", fwd0 - base, 8);
    chk("t2_last_forwarded", fwd0_last - base_last, 1);
    for (int k = 5; k <= 8; k++) begin
      chk("t2_next_pkt_stalled", m_tvalid[0], 0);
      chk("t2_s_tready_gated", s_tready[0], 0);
      chk("t2_route_old", route_out, exp_flat());
      tick();
    end                                                // T+9
    chk("t2_route_old_commit", route_out, exp_flat());
    tick();                                            // T+10
    exp_route[0] = 8'hA3;
    chk("t2_route_new", route_out, exp_flat());
    chk("t2_next_pkt_released", m_tvalid[0], 1);
    check_rsp();
    tick();
    s_tvalid[0] = 1'b0;
    s_tlast[0]  = 1'b0;
    chk("t2_total_forwarded", fwd0 - base, 9);

    // ---------------- pending beat with m_tready low ----------------
    m_tready[2] = 1'b0;
    s_tvalid[2] = 1'b1;
    s_tlast[2]  = 1'b1;
    do_req(8'd2, 8'h77, 2'b00);                       // T+1
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin
        m_tready[2] = 1'b1;
        #1;
      end
      chk("t3_pending_not_dropped", m_tvalid[2], 1);
      chk("t3_busy", busy, 1);
      tick();
    end                                                // T+4
    s_tvalid[2] = 1'b0;
    for (int k = 4; k <= 7; k++) begin
      chk("t3_gate_after_boundary", s_tready[2], 0);
      tick();
    end                                                // T+8 commit
    tick();                                            // T+9
    exp_route[2] = 8'h77;
    chk("t3_route_new", route_out, exp_flat());
    check_rsp();
    tick();

    // ---------------- bad id ----------------
    do_req(8'(N_ID), 8'h99, 2'b10);                   // T+1
    check_rsp();
    chk("t4_route_unchanged", route_out, exp_flat());
    tick();

    // ---------------- drain timeout ----------------
    s_tvalid[3] = 1'b1;
    s_tlast[3]  = 1'b0;
    tick();                                            // first beat accepted
    s_tvalid[3] = 1'b0;                                // held mid-packet
    do_req(8'd3, 8'h3C, 2'b01);                       // T+1
    for (int n = 1; n <= DT; n++) begin
      chk("t5_no_rsp_yet", cfg_rsp_valid, 0);
      chk("t5_gate_never", s_tready[3], 1);
      tick();
    end                                                // T+17
    check_rsp();
    chk("t5_route_unchanged", route_out, exp_flat());
    tick();

    // ---------------- reset during SETTLE ----------------
    do_req(8'd1, 8'hE1, 2'b00);                       // T+1
    tick();                                            // T+2
    chk("t6_gate_in_settle", s_tready[1], 0);
    tick();                                            // T+3
    areset = 1'b1;
    dropped = sb_q.pop_back();                        // request dropped by reset
    #1;
    chk("t6_req_ready_in_reset", cfg_req_ready, 0);
    tick();                                            // T+4
    for (int i = 0; i < N_ID; i++) exp_route[i] = DEF;
    chk("t6_gate_dropped", s_tready[1], 1);
    chk("t6_busy", busy, 0);
    chk("t6_rsp_valid", cfg_rsp_valid, 0);
    chk("t6_route_default", route_out, exp_flat());
    areset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("t6_no_spurious_rsp", cfg_rsp_valid, 0);
      tick();
    end
    do_req(8'd1, 8'h42, 2'b00);
    wait_rsp(SETTLE + 3);
    exp_route[1] = 8'h42;
    chk("t6_route_after_reset", route_out, exp_flat());
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
